// File: rtl/shift_arbiter.sv
// Two-requester round-robin front end for a single shared 16-bit shifter.
// Each operation runs IDLE -> EXEC -> OUT; the result is held in OUT until it is consumed.

module shifter (
    input  logic [15:0] data,
    input  logic [3:0]  amt,
    input  logic        mode,
    output logic [15:0] result
);
    always_comb begin
        if (mode) result = $signed(data) >>> amt;
        else      result = data << amt;
    end
endmodule

module shift_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic [15:0] in0,
    input  logic [3:0]  amt0,
    input  logic        mode0,
    input  logic        req1,
    input  logic [15:0] in1,
    input  logic [3:0]  amt1,
    input  logic        mode1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        res_valid,
    output logic [15:0] res_data,
    output logic        res_id,
    input  logic        res_ready
);
    // Result handshake: a result transfers on a rising edge where res_valid and res_ready are both high;
    // while res_valid is high, res_data and res_id do not change.
    typedef enum logic [1:0] {IDLE, EXEC, OUT} state_t;

    state_t      state, state_next;
    logic [15:0] op_data;
    logic [3:0]  op_amt;
    logic        op_mode;
    logic        op_id;
    logic        last_id;
    logic [15:0] shift_out;

    shifter u_shifter (
        .data   (op_data),
        .amt    (op_amt),
        .mode   (op_mode),
        .result (shift_out)
    );

    // On a tie the requester that was not granted last goes first.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state == IDLE && !rst) begin
            if (req0 && req1) begin
                gnt0 = last_id;
                gnt1 = !last_id;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (gnt0 || gnt1) state_next = EXEC;
            EXEC:    state_next = OUT;
            OUT:     if (res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign res_valid = (state == OUT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            op_data  <= 16'h0000;
            op_amt   <= 4'd0;
            op_mode  <= 1'b0;
            op_id    <= 1'b0;
            last_id  <= 1'b1;
            res_data <= 16'h0000;
            res_id   <= 1'b0;
        end else begin
            state <= state_next;
            if (gnt0) begin
                op_data <= in0;
                op_amt  <= amt0;
                op_mode <= mode0;
                op_id   <= 1'b0;
                last_id <= 1'b0;
            end else if (gnt1) begin
                op_data <= in1;
                op_amt  <= amt1;
                op_mode <= mode1;
                op_id   <= 1'b1;
                last_id <= 1'b1;
            end
            if (state == EXEC) begin
                res_data <= shift_out;
                res_id   <= op_id;
            end
        end
    end
endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: reset, single ops, tie round-robin, back-pressure,
// mid-op reset and a swept shift table against a bit-serial reference model.

module tb_shift_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        req0, mode0, req1, mode1, res_ready;
    logic [15:0] in0, in1;
    logic [3:0]  amt0, amt1;
    logic        gnt0, gnt1, res_valid, res_id;
    logic [15:0] res_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shift_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .in0       (in0),
        .amt0      (amt0),
        .mode0     (mode0),
        .req1      (req1),
        .in1       (in1),
        .amt1      (amt1),
        .mode1     (mode1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_id    (res_id),
        .res_ready (res_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    function automatic logic [15:0] ref_shift(input logic [15:0] d, input logic [3:0] a, input logic m);
        logic [15:0] r;
        r = d;
        for (int i = 0; i < int'(a); i++)
            r = m ? {r[15], r[15:1]} : {r[14:0], 1'b0};
        return r;
    endfunction

    // Issues one operation from IDLE with res_ready high and returns in the next IDLE cycle.
    task automatic do_op(input logic id, input logic [15:0] d, input logic [3:0] a, input logic m,
                         input logic [15:0] exp, input string tag);
        res_ready = 1'b1;
        if (id) begin req1 = 1'b1; in1 = d; amt1 = a; mode1 = m; end
        else    begin req0 = 1'b1; in0 = d; amt0 = a; mode0 = m; end
        #1;
        check({tag, "_gnt0"}, gnt0, !id);
        check({tag, "_gnt1"}, gnt1, id);
        next_cycle();
        req0 = 1'b0;
        req1 = 1'b0;
        #1;
        check({tag, "_exec_valid"}, res_valid, 0);
        next_cycle();
        #1;
        check({tag, "_valid"}, res_valid, 1);
        check({tag, "_data"}, res_data, exp);
        check({tag, "_id"}, res_id, id);
        next_cycle();
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    logic [15:0] ops [12];
    logic [15:0] exp0, exp1;

    initial begin
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; res_ready = 1'b0;
        in0 = 16'h0; amt0 = 4'd0; mode0 = 1'b0;
        in1 = 16'h0; amt1 = 4'd0; mode1 = 1'b0;
        next_cycle();
        // Reset wins over a pending request
        req0 = 1'b1;
        #1;
        check("rst_gnt0", gnt0, 0);
        check("rst_gnt1", gnt1, 0);
        next_cycle();
        #1;
        check("rst_valid", res_valid, 0);
        check("rst_data", res_data, 16'h0000);
        check("rst_id", res_id, 0);
        req0 = 1'b0;
        rst = 1'b0;
        next_cycle();

        // Single op, with a cycle-by-cycle latency check
        req0 = 1'b1; in0 = 16'h0001; amt0 = 4'd15; mode0 = 1'b0; res_ready = 1'b1;
        #1;
        check("single_gnt0_c0", gnt0, 1);
        check("single_gnt1_c0", gnt1, 0);
        next_cycle();
        req0 = 1'b0;
        #1;
        check("single_valid_c1", res_valid, 0);
        next_cycle();
        #1;
        check("single_valid_c2", res_valid, 1);
        check("single_data_c2", res_data, 16'h8000);
        check("single_id_c2", res_id, 0);
        next_cycle();
        #1;
        check("single_valid_c3", res_valid, 0);

        // SRA sign fill and zero amount through requester 1
        do_op(1'b1, 16'h8000, 4'd15, 1'b1, 16'hFFFF, "sra15");
        do_op(1'b1, 16'h8000, 4'd0, 1'b1, 16'h8000, "sra0");
        do_op(1'b0, 16'h00FF, 4'd4, 1'b1, 16'h000F, "sra_pos");
        do_op(1'b1, 16'hF00F, 4'd4, 1'b0, 16'h00F0, "sll_drop");

        // Tie right after reset: 0,1,0,1 with grants 3 cycles apart
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        req0 = 1'b1; in0 = 16'h0003; amt0 = 4'd1; mode0 = 1'b0;
        req1 = 1'b1; in1 = 16'h8000; amt1 = 4'd4; mode1 = 1'b1;
        res_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("tie_gnt0", gnt0, (k % 2) == 0);
            check("tie_gnt1", gnt1, (k % 2) == 1);
            next_cycle();
            #1;
            check("tie_exec_gnt", {gnt0, gnt1}, 0);
            next_cycle();
            #1;
            check("tie_out_gnt", {gnt0, gnt1}, 0);
            check("tie_valid", res_valid, 1);
            check("tie_id", res_id, k % 2);
            check("tie_data", res_data, (k % 2) ? 16'hF800 : 16'h0006);
            next_cycle();
        end
        req0 = 1'b0;
        req1 = 1'b0;

        // Back-pressure with requester 1 waiting
        req0 = 1'b1; in0 = 16'h00F0; amt0 = 4'd4; mode0 = 1'b0; res_ready = 1'b0;
        #1;
        check("bp_gnt0", gnt0, 1);
        next_cycle();
        req0 = 1'b0;
        req1 = 1'b1; in1 = 16'h0001; amt1 = 4'd1; mode1 = 1'b0;
        #1;
        check("bp_exec_gnt1", gnt1, 0);
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            #1;
            check("bp_valid", res_valid, 1);
            check("bp_data", res_data, 16'h0F00);
            check("bp_id", res_id, 0);
            check("bp_gnt", {gnt0, gnt1}, 0);
        end
        next_cycle();
        res_ready = 1'b1;
        #1;
        check("bp_release_valid", res_valid, 1);
        check("bp_release_gnt1", gnt1, 0);
        next_cycle();
        #1;
        check("bp_idle_gnt1", gnt1, 1);
        check("bp_idle_valid", res_valid, 0);
        next_cycle();
        req1 = 1'b0;
        next_cycle();
        #1;
        check("bp_r1_data", res_data, 16'h0002);
        check("bp_r1_id", res_id, 1);
        next_cycle();

        // Reset in EXEC discards the op; last_id returns to 1 so a tie grants 0
        req0 = 1'b1; in0 = 16'hFFFF; amt0 = 4'd1; mode0 = 1'b0;
        #1;
        check("mid_gnt0", gnt0, 1);
        next_cycle();
        req0 = 1'b0;
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        #1;
        check("mid_valid", res_valid, 0);
        check("mid_data", res_data, 16'h0000);
        check("mid_id", res_id, 0);
        next_cycle();
        #1;
        check("mid_no_stale", res_valid, 0);
        req0 = 1'b1; req1 = 1'b1;
        in0 = 16'h0001; amt0 = 4'd0; mode0 = 1'b0;
        #1;
        check("mid_tie_gnt0", gnt0, 1);
        check("mid_tie_gnt1", gnt1, 0);
        next_cycle();
        req0 = 1'b0; req1 = 1'b0;
        next_cycle();
        #1;
        check("mid_tie_id", res_id, 0);
        check("mid_tie_data", res_data, 16'h0001);
        next_cycle();

        // Shift sweep: all amounts and both modes over a spread of operands
        ops[0] = 16'h0001; ops[1] = 16'h8000; ops[2] = 16'hFFFF; ops[3] = 16'h0000;
        ops[4] = 16'hA5A5; ops[5] = 16'h5A5A; ops[6] = 16'h7FFF; ops[7] = 16'h1234;
        for (int i = 8; i < 12; i++) ops[i] = 16'($urandom_range(0, 65535));
        for (int o = 0; o < 12; o++)
            for (int a = 0; a < 16; a++)
                for (int m = 0; m < 2; m++) begin
                    exp0 = ref_shift(ops[o], 4'(a), 1'(m));
                    do_op(1'b0, ops[o], 4'(a), 1'(m), exp0, "sweep");
                end

        // Spot-check model against hand values
        exp1 = ref_shift(16'h8001, 4'd1, 1'b1);
        do_op(1'b0, 16'h8001, 4'd1, 1'b1, 16'hC000, "hand_sra1");
        check("model_sra1", exp1, 16'hC000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
